mul_accumulate: RTL

//  Downstream consumer of the 4x4 carry-save multiplier's 8-bit product.

---
 rtl/mul_accumulate_pkg.sv | 21 ++
 rtl/mul_acc_fsm.sv | 78 +++++++
 rtl/mul_accumulate.sv | 78 +++++++
 3 files changed

// File: rtl/mul_accumulate_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_accumulate_pkg : shared widths, state encoding and helpers      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mul_accumulate_pkg;

  localparam int PROD_W = 8;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // A one-term sum still needs a 1-bit counter port.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_acc_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_acc_fsm : term counting, handshake control and clr priority     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mul_acc_fsm
  import mul_accumulate_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             prod_valid,
  input  logic             acc_ready,
  output logic             prod_ready,
  output logic             acc_valid,
  output logic [CNT_W-1:0] term_cnt,
  output logic             acc_en,
  output logic             acc_clr
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clr overrides both handshakes; a beat presented alongside it is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    if (clr) begin
      state_d = ST_ACC;
      cnt_d   = '0;
      acc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (prod_valid) begin
            acc_en = 1'b1;
            if (cnt_q == LAST_CNT) begin
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (acc_ready) begin
            acc_clr = 1'b1;
            state_d = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign prod_ready = (state_q == ST_ACC);
  assign acc_valid  = (state_q == ST_HOLD);
  assign term_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mul_accumulate.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_accumulate : sums N_TERMS multiplier products per result        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mul_accumulate
  import mul_accumulate_pkg::*;
#(
  parameter int  N_TERMS = 4,
  parameter int  ACC_W   = 16,
  localparam int CNT_W   = cnt_width(N_TERMS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              acc_ovf,
  output logic [CNT_W-1:0]  term_cnt
);

  localparam int SUM_W = ACC_W + 1;

  logic             acc_en, acc_clr;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] sum_w;

  mul_acc_fsm #(
    .N_TERMS (N_TERMS),
    .CNT_W   (CNT_W)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .prod_valid (prod_valid),
    .acc_ready  (acc_ready),
    .prod_ready (prod_ready),
    .acc_valid  (acc_valid),
    .term_cnt   (term_cnt),
    .acc_en     (acc_en),
    .acc_clr    (acc_clr)
  );

  // Extra top bit captures the carry out of the accumulator width.
  assign sum_w = {1'b0, acc_q} + SUM_W'(prod);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (acc_clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (acc_en) begin
      acc_d = sum_w[ACC_W-1:0];
      ovf_d = ovf_q | sum_w[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc     = acc_q;
  assign acc_ovf = ovf_q;

endmodule
`default_nettype wire
